// File: rtl/fas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fas_pkg
//  Description : Shared definitions for the FIR frame collector. Holds the
//                default sample width and frame length, the bank state
//                encoding and the bank state transition helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fas_pkg;

    // Default sample width (two's complement, passed through unmodified)
    localparam int DW    = 16;
    // Default samples per frame (power of two, >= 2)
    localparam int FFT_N = 16;

    // Life cycle of one storage bank
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Next state of a bank.
    // A write always wins over an acknowledge. Writes into a FULL bank only
    // happen when the same edge acknowledges it, and that write lands at
    // index 0, so with N >= 2 it can never be the last word: the bank
    // reopens as FILLING rather than passing through EMPTY.
    function automatic bank_state_t bank_next_state(
        input bank_state_t cur,
        input logic        wr_en,
        input logic        wr_last,
        input logic        ack
    );
        bank_state_t nxt;
        nxt = cur;
        if (wr_en) begin
            nxt = wr_last ? BANK_FULL : BANK_FILLING;
        end else if (ack) begin
            nxt = BANK_EMPTY;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_frame_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fir_frame_bank
//  Description : One N x DW sample bank with its EMPTY/FILLING/FULL state.
//                Words are written one at a time at wr_idx; writing the
//                last word marks the bank FULL. An acknowledge from the
//                read side returns it to EMPTY.
//  Ports       : clk, rst        clock / async active-high reset
//                wr_en           store wr_d at wr_idx this edge
//                wr_idx          word index being written
//                wr_d            sample to store
//                wr_last         the write completes the frame
//                ack             downstream has taken this bank's frame
//                state           current bank state
//                data            bank contents, word k at [k*DW +: DW]
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_frame_bank
    import fas_pkg::*;
#(
    parameter int DW = fas_pkg::DW,
    parameter int N  = fas_pkg::FFT_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [$clog2(N)-1:0]   wr_idx,
    input  logic [DW-1:0]          wr_d,
    input  logic                   wr_last,
    input  logic                   ack,
    output bank_state_t            state,
    output logic [N*DW-1:0]        data
);

    localparam int IW = $clog2(N);

    bank_state_t r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BANK_EMPTY;
        end else begin
            r_state <= bank_next_state(r_state, wr_en, wr_last, ack);
        end
    end

    assign state = r_state;

    // Each word has its own decoded enable, so a write touches exactly one
    // register and the rest of the frame holds while the bank is read.
    for (genvar k = 0; k < N; k++) begin : g_word
        logic [DW-1:0] r_word;
        logic          w_sel;

        assign w_sel = wr_en && (wr_idx == IW'(k));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_word <= '0;
            end else if (w_sel) begin
                r_word <= wr_d;
            end
        end

        assign data[k*DW +: DW] = r_word;
    end

endmodule
`default_nettype wire

// File: rtl/fir_frame_collector.sv
`default_nettype none
// ============================================================================
//  Module      : fir_frame_collector
//  Description : Collects consecutive valid FIR samples into frames of N
//                words and hands each frame to the FFT stage as one wide
//                word over a valid/ready handshake. Two banks alternate so
//                the FIR keeps streaming while the FFT holds a frame.
//  Ports       : clk, rst        clock / async active-high reset
//                in_valid, in_d  incoming sample stream
//                frame_valid     a FULL bank is presented on frame_data
//                frame_ready     downstream accepts the presented frame
//                frame_data      word k at [k*DW +: DW], k=0 oldest
//                frame_cnt       frames handed over since reset (wraps)
//                overflow        sticky, a sample was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_frame_collector
    import fas_pkg::*;
#(
    parameter int DW = fas_pkg::DW,
    parameter int N  = fas_pkg::FFT_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_d,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [N*DW-1:0]   frame_data,
    output logic [7:0]        frame_cnt,
    output logic              overflow
);

    localparam int            IW         = $clog2(N);
    localparam logic [IW-1:0] c_LAST_IDX = IW'(N - 1);

    // ------------------------------------------------------------------
    // Pointers and status registers
    // ------------------------------------------------------------------
    logic          r_wr_bank;
    logic [IW-1:0] r_wr_idx;
    logic          r_rd_bank;
    logic [7:0]    r_frame_cnt;
    logic          r_overflow;

    // ------------------------------------------------------------------
    // Bank interface
    // ------------------------------------------------------------------
    bank_state_t     w_bank_state [2];
    logic [N*DW-1:0] w_bank_data  [2];
    logic            w_bank_wr_en [2];
    logic            w_bank_ack   [2];

    bank_state_t     w_wr_state;
    bank_state_t     w_rd_state;
    logic            w_frame_valid;
    logic            w_hs;
    logic            w_wr_free;
    logic            w_wr_en;
    logic            w_wr_last;
    logic            w_drop;

    assign w_wr_state = r_wr_bank ? w_bank_state[1] : w_bank_state[0];
    assign w_rd_state = r_rd_bank ? w_bank_state[1] : w_bank_state[0];

    // Valid depends only on registered bank state, never on the inputs.
    assign w_frame_valid = (w_rd_state == BANK_FULL);
    assign w_hs          = w_frame_valid && frame_ready;

    // The write bank accepts a sample unless it is FULL. A FULL write bank
    // is still usable when this very edge acknowledges it: that only
    // happens with both banks full, where write and read point at the same
    // bank, and the sample becomes word 0 of the reopened bank.
    assign w_wr_free = (w_wr_state != BANK_FULL) ||
                       (w_hs && (r_rd_bank == r_wr_bank));
    assign w_wr_en   = in_valid && w_wr_free;
    assign w_drop    = in_valid && !w_wr_free;
    assign w_wr_last = (r_wr_idx == c_LAST_IDX);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_bank_wr_en[b] = w_wr_en && (r_wr_bank == 1'(b));
        assign w_bank_ack[b]   = w_hs    && (r_rd_bank == 1'(b));

        fir_frame_bank #(
            .DW (DW),
            .N  (N)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (w_bank_wr_en[b]),
            .wr_idx  (r_wr_idx),
            .wr_d    (in_d),
            .wr_last (w_wr_last),
            .ack     (w_bank_ack[b]),
            .state   (w_bank_state[b]),
            .data    (w_bank_data[b])
        );
    end

    // ------------------------------------------------------------------
    // Write pointer, read pointer, frame counter and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_rd_bank   <= 1'b0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            // Dropped samples leave the index alone, so frame boundaries
            // stay aligned to accepted samples only.
            if (w_wr_en) begin
                if (w_wr_last) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_idx  <= r_wr_idx + 1'b1;
                end
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            if (w_hs) begin
                r_rd_bank   <= ~r_rd_bank;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Bank contents are registers that only change while a bank is being
    // filled, so the presented frame holds while the consumer stalls.
    assign frame_valid = w_frame_valid;
    assign frame_data  = r_rd_bank ? w_bank_data[1] : w_bank_data[0];
    assign frame_cnt   = r_frame_cnt;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fir_frame_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fir_frame_collector
//  Description : Self-checking bench for fir_frame_collector. A queue-based
//                reference model tracks the partial frame being gathered
//                and the completed frames waiting for the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_frame_collector;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int FW = DW * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_d = '0;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic [FW-1:0] frame_data;
    logic [7:0]    frame_cnt;
    logic          overflow;

    fir_frame_collector #(
        .DW (DW),
        .N  (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_d        (in_d),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_cnt   (frame_cnt),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Reference model: samples gathered so far, completed frames in order
    // ------------------------------------------------------------------
    logic [DW-1:0] m_part [$];
    logic [FW-1:0] m_full [$];
    logic [7:0]    m_cnt;
    logic          m_ovf;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_frame(input logic [DW-1:0] w [$]);
        logic [FW-1:0] r;
        r = '0;
        foreach (w[k]) r[k*DW +: DW] = w[k];
        return r;
    endfunction

    function automatic logic [DW-1:0] word_of(input logic [FW-1:0] f, input int k);
        return f[k*DW +: DW];
    endfunction

    task automatic model_reset();
        m_part.delete();
        m_full.delete();
        m_cnt = '0;
        m_ovf = 1'b0;
    endtask

    // Two banks of storage: a sample fits unless two complete frames are
    // still waiting after this edge's handover.
    task automatic model_step();
        bit hs;
        int waiting;
        hs      = (m_full.size() > 0) && frame_ready;
        waiting = m_full.size() - (hs ? 1 : 0);
        if (hs) begin
            void'(m_full.pop_front());
            m_cnt = m_cnt + 8'd1;
        end
        if (in_valid) begin
            if (waiting < 2) begin
                m_part.push_back(in_d);
                if (m_part.size() == N) begin
                    m_full.push_back(pack_frame(m_part));
                    m_part.delete();
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, FW'(frame_valid), FW'(m_full.size() > 0));
        check({tag, ".cnt"},   FW'(frame_cnt),   FW'(m_cnt));
        check({tag, ".ovf"},   FW'(overflow),    FW'(m_ovf));
        if (m_full.size() > 0) check({tag, ".data"}, frame_data, m_full[0]);
    endtask

    // One clock: inputs are applied 1ns after the previous edge, outputs
    // compared 1ns after this one.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
        in_valid    = v;
        in_d        = d;
        frame_ready = r;
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        #2;
        rst         = 1'b1;
        in_valid    = 1'b0;
        frame_ready = 1'b0;
        #1;
        model_reset();
        check("rst.valid", FW'(frame_valid), '0);
        check("rst.data",  frame_data,       '0);
        check("rst.cnt",   FW'(frame_cnt),   '0);
        check("rst.ovf",   FW'(overflow),    '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic check_ramp(input string tag, input int base);
        check({tag, ".v"}, FW'(frame_valid), FW'(1));
        for (int k = 0; k < N; k++)
            check($sformatf("%s.w%0d", tag, k), FW'(word_of(frame_data, k)), FW'(base + k));
    endtask

    initial begin
        model_reset();
        #12;
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Plain frame with ready held high
        do_reset();
        for (int k = 0; k < N; k++) cycle("t1", 1'b1, DW'(k), 1'b1);
        check_ramp("t1.frame", 0);
        cycle("t1", 1'b0, '0, 1'b1);
        check("t1.done.v",   FW'(frame_valid), '0);
        check("t1.done.cnt", FW'(frame_cnt),   FW'(1));

        // Both banks filled with ready low, then an extra sample is dropped
        do_reset();
        for (int k = 0; k < 2*N; k++) cycle("t2", 1'b1, DW'(k), 1'b0);
        cycle("t2", 1'b1, 16'h7FFF, 1'b0);
        check("t2.ovf", FW'(overflow), FW'(1));
        check_ramp("t2.f0", 0);
        cycle("t2", 1'b0, '0, 1'b1);
        check_ramp("t2.f1", N);
        cycle("t2", 1'b0, '0, 1'b1);
        check("t2.empty.v",   FW'(frame_valid), '0);
        check("t2.empty.cnt", FW'(frame_cnt),   FW'(2));

        // Gapped stream produces the same frame
        do_reset();
        for (int k = 0; k < N; k++) begin
            int gap;
            gap = $urandom_range(1, 5);
            for (int g = 0; g < gap; g++) cycle("t3", 1'b0, DW'($urandom), 1'b1);
            cycle("t3", 1'b1, DW'(k), 1'b1);
        end
        check_ramp("t3.frame", 0);

        // Handover and new sample on the same edge with both banks full
        do_reset();
        for (int k = 0; k < 2*N; k++) cycle("t4", 1'b1, DW'(100 + k), 1'b0);
        cycle("t4", 1'b1, 16'h1234, 1'b1);
        check("t4.ovf", FW'(overflow),  '0);
        check("t4.cnt", FW'(frame_cnt), FW'(1));
        check_ramp("t4.f1", 100 + N);
        cycle("t4", 1'b0, '0, 1'b1);
        for (int k = 1; k < N; k++) cycle("t4", 1'b1, DW'(k), 1'b0);
        check("t4.w0", FW'(word_of(frame_data, 0)), FW'(16'h1234));
        check("t4.w1", FW'(word_of(frame_data, 1)), FW'(1));

        // Reset in the middle of a frame
        do_reset();
        for (int k = 0; k < 10; k++) cycle("t5", 1'b1, DW'(50 + k), 1'b0);
        do_reset();
        for (int k = 0; k < N; k++) cycle("t5", 1'b1, DW'(200 + k), 1'b0);
        check_ramp("t5.frame", 200);

        // Negative samples, then frame counter wrap after 256 frames
        do_reset();
        for (int k = 0; k < N; k++) cycle("t6", 1'b1, (k % 2 == 0) ? 16'h8000 : 16'hFFFF, 1'b0);
        check("t6.w0", FW'(word_of(frame_data, 0)), FW'(16'h8000));
        check("t6.w1", FW'(word_of(frame_data, 1)), FW'(16'hFFFF));
        cycle("t6", 1'b0, '0, 1'b1);
        for (int k = 0; k < 255*N; k++) cycle("t6", 1'b1, DW'($urandom), 1'b1);
        cycle("t6", 1'b0, '0, 1'b1);
        check("t6.wrap", FW'(frame_cnt), '0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++)
            cycle("rnd", ($urandom_range(0, 9) < 7), DW'($urandom), $urandom_range(0, 1) == 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
